// File: rtl/mux16_scan_pkg.sv
`default_nettype none
// ============================================================
// mux16_scan_pkg: shared types and sizing for the mux16 scan sequencer
// Revision: 1.0
// ============================================================
package mux16_scan_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // The settle counter counts down from SETTLE_CYCLES-1 to 0.
    function automatic int settle_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux16_next_ch.sv
`default_nettype none
// ============================================================
// mux16_next_ch: lowest set mask bit at or above the given index
// Revision: 1.0
// ============================================================
module mux16_next_ch
    import mux16_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] rem_mask_i,
    input  logic [SEL_W-1:0]  cur_idx_i,
    output logic [SEL_W-1:0]  next_idx_o,
    output logic              none_left_o
);

    always_comb begin
        next_idx_o  = '0;
        none_left_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rem_mask_i[i] && (i >= int'(cur_idx_i))) begin
                next_idx_o  = SEL_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux16_scan_ctrl.sv
`default_nettype none
// ============================================================
// mux16_scan_ctrl: drives the 16:1 inverting mux and captures its output
// Revision: 1.0
// ============================================================
module mux16_scan_ctrl
    import mux16_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk_pad,
    input  logic              rst_pad,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic [SEL_W-1:0]  mux_sel_o,
    output logic              mux_en_n_o,
    input  logic              mux_v_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [NUM_CH-1:0] result_o,
    output logic              result_valid_o
);

    localparam int CNT_W = settle_cnt_w(int'(SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                en_n_q, en_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   result_q, result_d;
    logic                valid_q, valid_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_CH-1:0]   find_mask;
    logic [SEL_W-1:0]    find_idx;
    logic [SEL_W-1:0]    next_idx;
    logic                none_left;

    // In IDLE search the incoming mask from 0; otherwise search above the current channel.
    always_comb begin
        find_mask = mask_q & ~(NUM_CH'(1) << sel_q);
        find_idx  = sel_q;
        if (state_q == IDLE) begin
            find_mask = ch_mask_i;
            find_idx  = '0;
        end
    end

    mux16_next_ch u_next_ch (
        .rem_mask_i  (find_mask),
        .cur_idx_i   (find_idx),
        .next_idx_o  (next_idx),
        .none_left_o (none_left)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        result_d = result_q;
        valid_d  = valid_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (abort_i) begin
                    valid_d = 1'b0;
                end else if (start_i) begin
                    result_d = '0;
                    valid_d  = 1'b0;
                    mask_d   = ch_mask_i;
                    if (none_left) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEL;
                        sel_d   = next_idx;
                    end
                end
            end
            SEL: begin
                state_d = SETTLE;
                cnt_d   = c_settle_load;
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            SAMPLE: begin
                result_d[sel_q] = ~mux_v_i;
                mask_d          = find_mask;
                if (none_left) begin
                    state_d = DONE;
                end else begin
                    state_d = SEL;
                    sel_d   = next_idx;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort keeps the partial result and the select, but never reports it as valid.
        if (abort_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            sel_d    = sel_q;
            result_d = result_q;
            valid_d  = 1'b0;
        end

        en_n_d = !((state_d == SETTLE) || (state_d == SAMPLE));
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            en_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            en_n_q   <= en_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mux_sel_o      = sel_q;
    assign mux_en_n_o     = en_n_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux16_scan_ctrl.sv
`default_nettype none
// ============================================================
// tb_mux16_scan_ctrl: directed bench, two instances (SETTLE_CYCLES 1 and 3)
// Revision: 1.0
// ============================================================
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] mask = 16'h0;
    logic [15:0] data1 = 16'h0;
    logic [15:0] data3 = 16'h0;

    logic [3:0]  sel1, sel3;
    logic        en1, en3, v1, v3, busy1, busy3, done1, done3, val1, val3;
    logic [15:0] res1, res3;

    int checks = 0;
    int errors = 0;

    // Behavioural inverting mux: v = u | ~data[sel]
    assign v1 = en1 | ~data1[sel1];
    assign v3 = en3 | ~data3[sel3];

    mux16_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk_pad(clk), .rst_pad(rst), .start_i(start1), .abort_i(abort),
        .ch_mask_i(mask), .mux_sel_o(sel1), .mux_en_n_o(en1), .mux_v_i(v1),
        .busy_o(busy1), .done_o(done1), .result_o(res1), .result_valid_o(val1)
    );

    mux16_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk_pad(clk), .rst_pad(rst), .start_i(start3), .abort_i(abort),
        .ch_mask_i(mask), .mux_sel_o(sel3), .mux_en_n_o(en3), .mux_v_i(v3),
        .busy_o(busy3), .done_o(done3), .result_o(res3), .result_valid_o(val3)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sel1, en1, busy1, done1, res1, val1} !== {4'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut1 got sel=%h en_n=%b busy=%b done=%b res=%h valid=%b want 0 1 0 0 0000 0",
                     sel1, en1, busy1, done1, res1, val1);
        end
        checks++;
        if ({sel3, en3, busy3, done3, res3, val3} !== {4'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut3 got sel=%h en_n=%b busy=%b done=%b res=%h valid=%b want 0 1 0 0 0000 0",
                     sel3, en3, busy3, done3, res3, val3);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_scan();
        int n, changes, done_at;
        logic [3:0] prev;
        bit order_ok, en_ok;
        data1 = 16'hA5C3;
        prev = sel1; changes = 0; done_at = -1; order_ok = 1'b1; en_ok = 1'b1;
        @(negedge clk); mask = 16'hFFFF; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; n = 1;
        while (done_at < 0 && n <= 100) begin
            if (sel1 !== prev) begin
                changes++;
                if (en1 !== 1'b1) en_ok = 1'b0;
                if (sel1 !== prev + 4'd1) order_ok = 1'b0;
                prev = sel1;
            end
            if (done1 === 1'b1) done_at = n;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (done_at != 49) begin errors++; $display("FAIL full_done_cycle got %0d want 49", done_at); end
        checks++;
        if (changes != 15) begin errors++; $display("FAIL full_sel_changes got %0d want 15", changes); end
        checks++;
        if (!en_ok) begin errors++; $display("FAIL full_en_at_sel_change got 0 want 1"); end
        checks++;
        if (!order_ok) begin errors++; $display("FAIL full_sel_order got 0 want 1"); end
        checks++;
        if (res1 !== 16'hA5C3) begin errors++; $display("FAIL full_result got %h want a5c3", res1); end
        @(negedge clk);
        checks++;
        if (val1 !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", val1); end
    endtask

    task automatic test_sparse_mask();
        int n, done_at;
        logic [15:0] seen;
        data3 = 16'hFFFF; seen = 16'h0; done_at = -1;
        @(negedge clk); mask = 16'h8001; start3 = 1'b1;
        @(negedge clk); start3 = 1'b0; n = 1;
        while (done_at < 0 && n <= 100) begin
            if (busy3 === 1'b1 && done3 !== 1'b1) seen[sel3] = 1'b1;
            if (done3 === 1'b1) done_at = n;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (done_at != 11) begin errors++; $display("FAIL sparse_done_cycle got %0d want 11", done_at); end
        checks++;
        if (seen !== 16'h8001) begin errors++; $display("FAIL sparse_visited got %h want 8001", seen); end
        checks++;
        if (res3 !== 16'h8001) begin errors++; $display("FAIL sparse_result got %h want 8001", res3); end
        @(negedge clk);
        checks++;
        if (val3 !== 1'b1) begin errors++; $display("FAIL sparse_valid got %b want 1", val3); end
    endtask

    task automatic test_empty_mask();
        @(negedge clk); mask = 16'h0000; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        checks++;
        if ({done1, en1, busy1, val1, res1} !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL empty_done got done=%b en_n=%b busy=%b valid=%b res=%h want 1 1 1 0 0000",
                     done1, en1, busy1, val1, res1);
        end
        @(negedge clk);
        checks++;
        if ({done1, en1, busy1, val1, res1} !== {1'b0, 1'b1, 1'b0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL empty_after got done=%b en_n=%b busy=%b valid=%b res=%h want 0 1 0 1 0000",
                     done1, en1, busy1, val1, res1);
        end
    endtask

    task automatic test_abort();
        int n, done_at;
        data1 = 16'hA5C3;
        @(negedge clk); mask = 16'hFFFF; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        // Channel k settles in cycle 3k+2 after the accept edge.
        for (int i = 1; i < 17; i++) @(negedge clk);
        checks++;
        if ({sel1, en1} !== {4'd5, 1'b0}) begin
            errors++; $display("FAIL abort_in_settle got sel=%h en_n=%b want 5 0", sel1, en1);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({busy1, en1, done1, val1} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_idle got busy=%b en_n=%b done=%b valid=%b want 0 1 0 0", busy1, en1, done1, val1);
        end
        checks++;
        if (res1 !== 16'h0003) begin errors++; $display("FAIL abort_partial got %h want 0003", res1); end
        @(negedge clk);
        checks++;
        if ({busy1, done1, val1} !== 3'b000) begin
            errors++; $display("FAIL abort_no_done got busy=%b done=%b valid=%b want 000", busy1, done1, val1);
        end
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; n = 1; done_at = -1;
        checks++;
        if ({sel1, en1, busy1} !== {4'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL rescan_start got sel=%h en_n=%b busy=%b want 0 1 1", sel1, en1, busy1);
        end
        while (done_at < 0 && n <= 100) begin
            if (done1 === 1'b1) done_at = n;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (done_at != 49) begin errors++; $display("FAIL rescan_done_cycle got %0d want 49", done_at); end
        checks++;
        if (res1 !== 16'hA5C3) begin errors++; $display("FAIL rescan_result got %h want a5c3", res1); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int n, done_at;
        bit busy_ok;
        data1 = 16'hA5C3; busy_ok = 1'b1; done_at = -1;
        @(negedge clk); mask = 16'h00F0; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; n = 1;
        while (done_at < 0 && n <= 100) begin
            if (n == 5) begin start1 = 1'b1; mask = 16'hFFFF; end
            if (n == 6) begin start1 = 1'b0; mask = 16'h0000; end
            if (done1 === 1'b1) done_at = n;
            else begin
                if (busy1 !== 1'b1) busy_ok = 1'b0;
                @(negedge clk); n++;
            end
        end
        checks++;
        if (done_at != 13) begin errors++; $display("FAIL midscan_done_cycle got %0d want 13", done_at); end
        checks++;
        if (!busy_ok) begin errors++; $display("FAIL midscan_busy got 0 want 1"); end
        checks++;
        if (res1 !== 16'h00C0) begin errors++; $display("FAIL midscan_result got %h want 00c0", res1); end
        @(negedge clk);
        mask = 16'hFFFF; start1 = 1'b1; abort = 1'b1;
        @(negedge clk); start1 = 1'b0; abort = 1'b0;
        checks++;
        if ({busy1, en1, done1} !== {1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL start_abort got busy=%b en_n=%b done=%b want 0 1 0", busy1, en1, done1);
        end
        @(negedge clk);
        checks++;
        if ({busy1, done1} !== 2'b00) begin
            errors++; $display("FAIL start_abort_later got busy=%b done=%b want 0 0", busy1, done1);
        end
    endtask

    task automatic test_async_reset();
        data3 = 16'hA5C3;
        @(negedge clk); mask = 16'hFFFF; start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        // With three settle cycles, channel 2 samples in cycle 15 after the accept edge.
        for (int i = 1; i < 15; i++) @(negedge clk);
        checks++;
        if ({sel3, en3, busy3} !== {4'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL pre_reset_sample got sel=%h en_n=%b busy=%b want 2 0 1", sel3, en3, busy3);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sel3, en3, busy3, done3, res3, val3} !== {4'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got sel=%h en_n=%b busy=%b done=%b res=%h valid=%b want 0 1 0 0 0000 0",
                     sel3, en3, busy3, done3, res3, val3);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy3, en3, done3} !== {1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL post_reset got busy=%b en_n=%b done=%b want 0 1 0", busy3, en3, done3);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_empty_mask();
        test_abort();
        test_ignored_start();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
